// File: rtl/power_of_8_pkg.sv
// Shared widths and engine timing for the power_of_8 engine and the arbiter in front of it.
package power_of_8_pkg;

  localparam int VALUE_W      = 32;
  localparam int RESULT_W     = 64;
  localparam int POW8_LATENCY = 3;

  // Index reached by stepping `offset` places up from `base`, wrapping at n.
  function automatic int rr_index(input int base, input int offset, input int n);
    int s;
    s = base + offset;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of requester IDs, one entry per operation outstanding in the engine.
module tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [W-1:0]                 din_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_eff, pop_eff;

  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign push_eff = push_i && !full_o;
  assign pop_eff  = pop_i && !empty_o;

  // Head is read combinationally so the tag is available in the same cycle as the engine result.
  assign dout_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_eff) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_eff) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/power_of_8_arbiter.sv
// Round-robin front end sharing one power_of_8 engine between N_REQ requesters,
// routing each in-order engine result back to the requester that issued it.
module power_of_8_arbiter
  import power_of_8_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ*VALUE_W-1:0]   i_req_value,
  output logic                       o_eng_valid,
  output logic [VALUE_W-1:0]         o_eng_value,
  input  logic                       i_eng_valid,
  input  logic [RESULT_W-1:0]        i_eng_result,
  output logic                       o_rsp_valid,
  output logic [ID_W-1:0]            o_rsp_id,
  output logic [RESULT_W-1:0]        o_rsp_result,
  output logic                       o_busy,
  output logic                       o_err
);

  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  logic [VALUE_W-1:0]  req_value [N_REQ];

  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     winner, cand;
  logic                found, can_issue, fire;

  logic                eng_valid_q, eng_valid_d;
  logic [VALUE_W-1:0]  eng_value_q, eng_value_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [RESULT_W-1:0] rsp_result_q, rsp_result_d;
  logic                err_q, err_d;

  logic                fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0]     fifo_head;
  logic [CNT_W-1:0]    fifo_count;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_value[gi]   = i_req_value[gi*VALUE_W +: VALUE_W];
      assign o_req_ready[gi] = fire && (winner == ID_W'(gi));
    end
  endgenerate

  // Full means fifo_count has reached TAG_DEPTH; a same-cycle pop is not credited until next cycle.
  assign can_issue = !fifo_full;
  assign fire      = found && can_issue;

  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_W'(rr_index(int'(ptr_q), i, N_REQ));
      if (!found && i_req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign fifo_pop = i_eng_valid && !fifo_empty;

  always_comb begin
    ptr_d        = ptr_q;
    eng_valid_d  = fire;
    eng_value_d  = eng_value_q;
    rsp_valid_d  = fifo_pop;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    err_d        = err_q;
    if (fire) begin
      eng_value_d = req_value[winner];
      ptr_d       = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end
    if (fifo_pop) begin
      rsp_id_d     = fifo_head;
      rsp_result_d = i_eng_result;
    end
    // A result with no tag outstanding means the engine and arbiter have lost sync.
    if (i_eng_valid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      eng_valid_q  <= 1'b0;
      eng_value_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      eng_valid_q  <= eng_valid_d;
      eng_value_q  <= eng_value_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      err_q        <= err_d;
    end
  end

  tag_fifo #(
    .W     (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fire),
    .din_i   (winner),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign o_eng_valid  = eng_valid_q;
  assign o_eng_value  = eng_value_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_result = rsp_result_q;
  assign o_err        = err_q;
  assign o_busy       = (fifo_count != '0) || eng_valid_q;

endmodule
